// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register: two-entry skid buffer (SKID=1) or
// single-entry stage (SKID=0), with synchronous flush and active-low reset.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int N_DATA = 4,
   parameter int CTRL_W = 16,
   parameter int SKID   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_DATA*DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0]        in_ctrl,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_DATA*DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [1:0]               occupancy
);

   localparam int PW = N_DATA * DATA_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [PW-1:0]     head_data;
   logic [PW-1:0]     skid_data;
   logic [CTRL_W-1:0] head_ctrl;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              rdy_q;
   logic              in_fire;
   logic              out_fire;
   logic              load_head;
   logic              load_skid;
   logic              pop_skid;

   assign out_valid = (state != EMPTY);
   assign occupancy = state;
   assign out_data  = head_data;
   assign out_ctrl  = out_valid ? head_ctrl : '0;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // rdy_q is low through reset and the edge that ends it in both modes
   always_comb begin
      if (SKID != 0) begin
         in_ready = rst & rdy_q;
      end else begin
         in_ready = rst & rdy_q & (~out_valid | out_ready);
      end
   end

   always_comb begin
      state_nx  = state;
      load_head = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
      unique case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nx  = ONE;
               load_head = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_head = 1'b1;
            end else if (in_fire) begin
               state_nx  = FULL;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_nx  = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_nx = ONE;
               pop_skid = 1'b1;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= EMPTY;
         rdy_q     <= 1'b0;
         head_data <= '0;
         skid_data <= '0;
         head_ctrl <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         // data is kept so out_data holds its last head value
         state     <= EMPTY;
         rdy_q     <= 1'b1;
         head_ctrl <= '0;
         skid_ctrl <= '0;
      end else begin
         state <= state_nx;
         rdy_q <= (state_nx != FULL);
         if (load_head) begin
            head_data <= in_data;
            head_ctrl <= in_ctrl;
         end else if (pop_skid) begin
            head_data <= skid_data;
            head_ctrl <= skid_ctrl;
         end
         if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and single-entry instances driven in
// parallel and compared against a FIFO reference model.
module tb_pipe_stage_reg;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_data;
   logic [7:0]  in_ctrl;

   logic        a_in_ready, a_out_valid;
   logic [31:0] a_out_data;
   logic [7:0]  a_out_ctrl;
   logic [1:0]  a_occ;
   logic        b_in_ready, b_out_valid;
   logic [31:0] b_out_data;
   logic [7:0]  b_out_ctrl;
   logic [1:0]  b_occ;

   int passes = 0;
   int checks = 0;

   // reference model: FIFO contents {ctrl,data}, depth and last head data
   logic [39:0] ent [2][2];
   int          cnt [2];
   logic [31:0] hd  [2];
   bit          rdy_ok = 0;

   pipe_stage_reg #(.DATA_W(16), .N_DATA(2), .CTRL_W(8), .SKID(1)) u_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_ctrl(a_out_ctrl),
      .occupancy(a_occ)
   );

   pipe_stage_reg #(.DATA_W(16), .N_DATA(2), .CTRL_W(8), .SKID(0)) u_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_ctrl(b_out_ctrl),
      .occupancy(b_occ)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] req);
      checks++;
      assert (obs === req) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
   endtask

   function automatic bit exp_rdy(input int i);
      if (!rst || !rdy_ok) return 1'b0;
      if (i == 0) return cnt[0] < 2;
      return (cnt[1] == 0) || out_ready;
   endfunction

   task automatic upd(input int i);
      bit ir;
      ir = exp_rdy(i);
      if (!rst) begin
         cnt[i] = 0;
         hd[i]  = '0;
      end else begin
         if (cnt[i] > 0 && out_ready) begin
            ent[i][0] = ent[i][1];
            cnt[i]--;
         end
         if (in_valid && ir) begin
            ent[i][cnt[i]] = {in_ctrl, in_data};
            cnt[i]++;
         end
         if (flush) cnt[i] = 0;
         if (cnt[i] > 0) hd[i] = ent[i][0][31:0];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      upd(0);
      upd(1);
      rdy_ok = rst;
      @(negedge clk);
   endtask

   task automatic check_all();
      #1;
      chk("a_valid", a_out_valid, cnt[0] > 0);
      chk("a_occ", a_occ, cnt[0]);
      chk("a_rdy", a_in_ready, exp_rdy(0));
      chk("a_ctrl", a_out_ctrl, cnt[0] > 0 ? ent[0][0][39:32] : 8'h0);
      chk("a_data", a_out_data, hd[0]);
      chk("b_valid", b_out_valid, cnt[1] > 0);
      chk("b_occ", b_occ, cnt[1]);
      chk("b_rdy", b_in_ready, exp_rdy(1));
      chk("b_ctrl", b_out_ctrl, cnt[1] > 0 ? ent[1][0][39:32] : 8'h0);
      chk("b_data", b_out_data, hd[1]);
   endtask

   task automatic sd(input logic v, input logic [15:0] w,
                     input logic [7:0] c, input logic r);
      in_valid  = v;
      in_data   = {16'h0, w};
      in_ctrl   = c;
      out_ready = r;
   endtask

   initial begin
      cnt[0] = 0;
      cnt[1] = 0;
      hd[0]  = '0;
      hd[1]  = '0;
      rst    = 1'b0;
      flush  = 1'b0;
      sd(1'b1, 16'h55, 8'h5, 1'b0);
      tick();
      tick();
      check_all();
      chk("rst_occ", a_occ, 0);
      chk("rst_valid", a_out_valid, 0);
      chk("rst_rdy", a_in_ready, 0);

      rst = 1'b1;
      sd(1'b0, 16'h0, 8'h0, 1'b0);
      check_all();
      tick();

      sd(1'b1, 16'h11, 8'h01, 1'b1);
      check_all();
      tick();
      sd(1'b0, 16'h0, 8'h0, 1'b0);
      check_all();
      chk("p1_valid", a_out_valid, 1);
      chk("p1_word0", a_out_data[15:0], 16'h11);
      chk("p1_ctrl", a_out_ctrl, 8'h01);
      chk("p1_occ", a_occ, 1);
      sd(1'b0, 16'h0, 8'h0, 1'b1);
      check_all();
      tick();

      sd(1'b1, 16'h0A, 8'h0A, 1'b0);
      check_all();
      tick();
      sd(1'b1, 16'h0B, 8'h0B, 1'b0);
      check_all();
      chk("s0_b_rdy_held", b_in_ready, 0);
      tick();
      sd(1'b0, 16'h0, 8'h0, 1'b0);
      check_all();
      chk("skid_occ2", a_occ, 2);
      chk("skid_rdy0", a_in_ready, 0);
      sd(1'b0, 16'h0, 8'h0, 1'b1);
      check_all();
      chk("skid_first", a_out_data[15:0], 16'h0A);
      tick();
      check_all();
      chk("skid_second", a_out_data[15:0], 16'h0B);
      chk("skid_rdy1", a_in_ready, 1);
      tick();

      sd(1'b1, 16'h21, 8'h21, 1'b0);
      check_all();
      tick();
      sd(1'b1, 16'h22, 8'h22, 1'b0);
      check_all();
      tick();
      flush = 1'b1;
      sd(1'b1, 16'h0C, 8'h0C, 1'b0);
      check_all();
      tick();
      flush = 1'b0;
      sd(1'b0, 16'h0, 8'h0, 1'b0);
      check_all();
      chk("fl_occ", a_occ, 0);
      chk("fl_valid", a_out_valid, 0);
      chk("fl_ctrl", a_out_ctrl, 0);
      chk("fl_word0", a_out_data[15:0], 16'h21);

      sd(1'b1, 16'h31, 8'h31, 1'b0);
      check_all();
      tick();
      sd(1'b1, 16'h0D, 8'h0D, 1'b1);
      check_all();
      tick();
      sd(1'b0, 16'h0, 8'h0, 1'b0);
      check_all();
      chk("both_occ", a_occ, 1);
      chk("both_word0", a_out_data[15:0], 16'h0D);

      sd(1'b1, 16'h0E, 8'h0E, 1'b0);
      check_all();
      chk("s0_rdy0", b_in_ready, 0);
      sd(1'b1, 16'h0E, 8'h0E, 1'b1);
      check_all();
      tick();
      sd(1'b0, 16'h0, 8'h0, 1'b0);
      check_all();
      chk("s0_pass", b_out_data[15:0], 16'h0E);
      chk("s0_occ", b_occ, 1);
      sd(1'b0, 16'h0, 8'h0, 1'b1);
      check_all();
      tick();

      sd(1'b1, 16'h41, 8'h41, 1'b0);
      check_all();
      tick();
      sd(1'b1, 16'h42, 8'h42, 1'b0);
      check_all();
      tick();
      sd(1'b0, 16'h0, 8'h0, 1'b0);
      check_all();
      chk("full_occ", a_occ, 2);
      rst = 1'b0;
      tick();
      check_all();
      chk("rf_occ", a_occ, 0);
      chk("rf_valid", a_out_valid, 0);
      chk("rf_rdy", a_in_ready, 0);
      rst = 1'b1;
      check_all();
      chk("rf_rdy_rel", a_in_ready, 0);
      tick();
      check_all();
      chk("rf_rdy_up", a_in_ready, 1);
      chk("rf_nopulse", a_out_valid, 0);

      for (int n = 0; n < 500; n++) begin
         rst       = ($urandom_range(0, 59) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         out_ready = $urandom_range(0, 9) < 6;
         in_data   = $urandom;
         in_ctrl   = 8'($urandom_range(0, 255));
         check_all();
         tick();
      end
      rst = 1'b1;
      flush = 1'b0;
      check_all();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of one data word.
REQ-002 SHALL have parameter N_DATA, default 4, meaning number of data words per payload; must be at least 1.
REQ-003 SHALL have parameter CTRL_W, default 16, meaning width of the control bundle, which is zeroed on bubbles.
REQ-004 SHALL have parameter SKID, default 1; 1 selects the two-entry skid mode, 0 selects the single-entry mode.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (reset when rst==0 at the clk rising edge).
REQ-007 SHALL have port flush, input, 1 bit: synchronous squash of all held entries.
REQ-008 SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the stage accepts a payload this cycle.
REQ-010 SHALL have port in_data, input, N_DATA*DATA_W bits: upstream data payload; word k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port in_ctrl, input, CTRL_W bits: upstream control bundle.
REQ-012 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-014 SHALL have port out_data, output, N_DATA*DATA_W bits: head entry data.
REQ-015 SHALL have port out_ctrl, output, CTRL_W bits: head entry control; all zero whenever out_valid==0.
REQ-016 SHALL have port occupancy, output, 2 bits: number of held entries (0..2).

Function
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; a transfer occurs only on a fire.
REQ-018 SHALL, when SKID=1, implement FSM states EMPTY(0), ONE(1) and FULL(2), with occupancy equal to the state encoding.
REQ-019 SHALL, when SKID=1, drive in_ready = (state != FULL) from a register, with no combinational path from out_ready.
REQ-020 SHALL drive out_valid = (state != EMPTY).
REQ-021 SHALL make these FSM transitions:
- EMPTY with in_fire -> ONE, head <= in.
- ONE with in_fire and no out_fire -> FULL, skid <= in.
- ONE with out_fire and no in_fire -> EMPTY.
- ONE with both -> ONE, head <= in.
- FULL with out_fire -> ONE, head <= skid.
- All other cases hold.
REQ-022 SHALL preserve FIFO order; a payload is never duplicated or dropped except by flush.
REQ-023 SHALL have a latency of 1 cycle: a payload accepted at edge N is visible on out_* after edge N when the stage was EMPTY, or when it was ONE with a simultaneous out_fire.
REQ-024 SHALL, when SKID=0, hold a single entry with in_ready = !out_valid | out_ready (combinational) and occupancy limited to 0 or 1.
REQ-025 SHALL make flush==1 at an edge force EMPTY, discard any in_fire of that cycle, and zero the stored ctrl of both entries; stored data is left unchanged.
REQ-026 SHALL give flush priority over in_fire and out_fire; out_fire in a flush cycle still counts as consumed by downstream.
REQ-027 SHALL hold out_data at its last head value while out_valid==0.
REQ-028 SHALL keep out_data and out_ctrl stable while out_valid==1 and out_ready==0.

Reset
REQ-029 SHALL, on rst==0 at an edge, force EMPTY, zero the head and skid data and ctrl, set occupancy=0 and out_valid=0, and ignore in_valid/flush that cycle.
REQ-030 SHALL drive in_ready=0 while rst==0 and in_ready=1 from the first edge after rst returns to 1.
REQ-031 SHALL, when reset is asserted with entries held, discard them with no out_valid pulse afterward.

Verification
REQ-032 The bench SHALL cover: reset, then in_valid=1, in_data word0=0x11, in_ctrl=0x0001, out_ready=1 -> next cycle out_valid=1, word0=0x11, out_ctrl=0x0001, occupancy=1.
REQ-033 The bench SHALL cover: SKID=1, out_ready=0, inputs 0xA then 0xB -> occupancy=2, in_ready=0; then out_ready=1 -> 0xA, then 0xB, in order, and in_ready=1 after the first pop.
REQ-034 The bench SHALL cover: FULL state with flush=1 and in_valid=1 (0xC) -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0xC never appears on the output.
REQ-035 The bench SHALL cover: ONE state with simultaneous in_fire (0xD) and out_fire -> occupancy stays 1 and out_data word0=0xD.
REQ-036 The bench SHALL cover: SKID=0, out_ready=0 with an entry held -> in_ready=0; out_ready=1 with in_valid (0xE) -> pass-through, with 0xE on the output the next cycle.
REQ-037 The bench SHALL cover: rst=0 while FULL -> next cycle occupancy=0, out_valid=0, in_ready=0; rst=1 -> in_ready=1 on the following cycle.
